// File: rtl/axi_port_arbiter.sv
// Two-requester round-robin arbiter for a single AXI4 control port.
// Grants whole single-beat write (AW+W+B) or read (AR+R) transactions, one outstanding at a time.
module axi_port_arbiter #(
    parameter int AW  = 32,
    parameter int DW  = 32,
    parameter int IDW = 1
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_ni,
    // requester 0
    input  logic              m0_awvalid,
    output logic              m0_awready,
    input  logic [AW-1:0]     m0_awaddr,
    input  logic [IDW-1:0]    m0_awid,
    input  logic              m0_wvalid,
    output logic              m0_wready,
    input  logic [DW-1:0]     m0_wdata,
    input  logic [DW/8-1:0]   m0_wstrb,
    output logic              m0_bvalid,
    input  logic              m0_bready,
    output logic [1:0]        m0_bresp,
    output logic [IDW-1:0]    m0_bid,
    input  logic              m0_arvalid,
    output logic              m0_arready,
    input  logic [AW-1:0]     m0_araddr,
    input  logic [IDW-1:0]    m0_arid,
    output logic              m0_rvalid,
    input  logic              m0_rready,
    output logic [DW-1:0]     m0_rdata,
    output logic [1:0]        m0_rresp,
    output logic [IDW-1:0]    m0_rid,
    output logic              m0_rlast,
    // requester 1
    input  logic              m1_awvalid,
    output logic              m1_awready,
    input  logic [AW-1:0]     m1_awaddr,
    input  logic [IDW-1:0]    m1_awid,
    input  logic              m1_wvalid,
    output logic              m1_wready,
    input  logic [DW-1:0]     m1_wdata,
    input  logic [DW/8-1:0]   m1_wstrb,
    output logic              m1_bvalid,
    input  logic              m1_bready,
    output logic [1:0]        m1_bresp,
    output logic [IDW-1:0]    m1_bid,
    input  logic              m1_arvalid,
    output logic              m1_arready,
    input  logic [AW-1:0]     m1_araddr,
    input  logic [IDW-1:0]    m1_arid,
    output logic              m1_rvalid,
    input  logic              m1_rready,
    output logic [DW-1:0]     m1_rdata,
    output logic [1:0]        m1_rresp,
    output logic [IDW-1:0]    m1_rid,
    output logic              m1_rlast,
    // slave side toward ioMem_0
    output logic              s_awvalid,
    input  logic              s_awready,
    output logic [AW-1:0]     s_awaddr,
    output logic [IDW:0]      s_awid,
    output logic              s_wvalid,
    input  logic              s_wready,
    output logic [DW-1:0]     s_wdata,
    output logic [DW/8-1:0]   s_wstrb,
    input  logic              s_bvalid,
    output logic              s_bready,
    input  logic [1:0]        s_bresp,
    input  logic [IDW:0]      s_bid,
    output logic              s_arvalid,
    input  logic              s_arready,
    output logic [AW-1:0]     s_araddr,
    output logic [IDW:0]      s_arid,
    input  logic              s_rvalid,
    output logic              s_rready,
    input  logic [DW-1:0]     s_rdata,
    input  logic [1:0]        s_rresp,
    input  logic [IDW:0]      s_rid,
    input  logic              s_rlast,
    output logic              busy_o,
    output logic              grant_o
);

    typedef enum logic [2:0] {IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_DATA} state_t;

    state_t state_reg, state_next;
    logic   grant_reg, grant_next;
    logic   last_grant_reg, last_grant_next;
    logic   aw_done_reg, aw_done_next;
    logic   w_done_reg, w_done_next;

    logic [1:0]      awvalid_v, wvalid_v, arvalid_v, bready_v, rready_v;
    logic [1:0]      wr_req, req, sel;
    logic [1:0]      awready_v, wready_v, arready_v, bvalid_v, rvalid_v;
    logic [AW-1:0]   awaddr_v [2];
    logic [AW-1:0]   araddr_v [2];
    logic [IDW-1:0]  awid_v [2];
    logic [IDW-1:0]  arid_v [2];
    logic [DW-1:0]   wdata_v [2];
    logic [DW/8-1:0] wstrb_v [2];
    logic            pick, aw_hs, w_hs;
    logic            lane_awready, lane_wready, lane_arready, lane_bvalid, lane_rvalid;
    logic            unused_id_msb;

    assign awvalid_v = {m1_awvalid, m0_awvalid};
    assign wvalid_v  = {m1_wvalid,  m0_wvalid};
    assign arvalid_v = {m1_arvalid, m0_arvalid};
    assign bready_v  = {m1_bready,  m0_bready};
    assign rready_v  = {m1_rready,  m0_rready};
    assign awaddr_v  = '{m0_awaddr, m1_awaddr};
    assign araddr_v  = '{m0_araddr, m1_araddr};
    assign awid_v    = '{m0_awid,   m1_awid};
    assign arid_v    = '{m0_arid,   m1_arid};
    assign wdata_v   = '{m0_wdata,  m1_wdata};
    assign wstrb_v   = '{m0_wstrb,  m1_wstrb};

    assign wr_req = awvalid_v & wvalid_v;
    assign req    = wr_req | arvalid_v;

    // Request payload always follows the granted lane; valids are gated by the FSM.
    assign s_awaddr = awaddr_v[grant_reg];
    assign s_awid   = {grant_reg, awid_v[grant_reg]};
    assign s_wdata  = wdata_v[grant_reg];
    assign s_wstrb  = wstrb_v[grant_reg];
    assign s_araddr = araddr_v[grant_reg];
    assign s_arid   = {grant_reg, arid_v[grant_reg]};

    // The ID MSB is ignored on responses: with one outstanding the grant is authoritative.
    assign unused_id_msb = s_bid[IDW] ^ s_rid[IDW];

    always_comb begin
        state_next      = state_reg;
        grant_next      = grant_reg;
        last_grant_next = last_grant_reg;
        aw_done_next    = aw_done_reg;
        w_done_next     = w_done_reg;
        pick            = 1'b0;
        aw_hs           = 1'b0;
        w_hs            = 1'b0;
        s_awvalid       = 1'b0;
        s_wvalid        = 1'b0;
        s_arvalid       = 1'b0;
        s_bready        = 1'b0;
        s_rready        = 1'b0;
        lane_awready    = 1'b0;
        lane_wready     = 1'b0;
        lane_arready    = 1'b0;
        lane_bvalid     = 1'b0;
        lane_rvalid     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (|req) begin
                    pick       = (&req) ? ~last_grant_reg : req[1];
                    grant_next = pick;
                    state_next = wr_req[pick] ? WR_ADDR : RD_ADDR;
                end
            end
            WR_ADDR: begin
                s_awvalid    = awvalid_v[grant_reg] & ~aw_done_reg;
                s_wvalid     = wvalid_v[grant_reg] & ~w_done_reg;
                lane_awready = s_awready & ~aw_done_reg;
                lane_wready  = s_wready & ~w_done_reg;
                aw_hs        = s_awvalid & s_awready;
                w_hs         = s_wvalid & s_wready;
                aw_done_next = aw_done_reg | aw_hs;
                w_done_next  = w_done_reg | w_hs;
                if ((aw_done_reg | aw_hs) & (w_done_reg | w_hs)) begin
                    state_next   = WR_RESP;
                    aw_done_next = 1'b0;
                    w_done_next  = 1'b0;
                end
            end
            WR_RESP: begin
                s_bready    = bready_v[grant_reg];
                lane_bvalid = s_bvalid;
                if (s_bvalid & s_bready) begin
                    state_next      = IDLE;
                    last_grant_next = grant_reg;
                end
            end
            RD_ADDR: begin
                s_arvalid    = arvalid_v[grant_reg];
                lane_arready = s_arready;
                if (s_arvalid & s_arready) begin
                    state_next = RD_DATA;
                end
            end
            RD_DATA: begin
                s_rready    = rready_v[grant_reg];
                lane_rvalid = s_rvalid;
                if (s_rvalid & s_rready & s_rlast) begin
                    state_next      = IDLE;
                    last_grant_next = grant_reg;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Handshake signals reach only the granted requester.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_lane
            assign sel[gi]       = (gi == 0) ? ~grant_reg : grant_reg;
            assign awready_v[gi] = sel[gi] & lane_awready;
            assign wready_v[gi]  = sel[gi] & lane_wready;
            assign arready_v[gi] = sel[gi] & lane_arready;
            assign bvalid_v[gi]  = sel[gi] & lane_bvalid;
            assign rvalid_v[gi]  = sel[gi] & lane_rvalid;
        end
    endgenerate

    assign m0_awready = awready_v[0];
    assign m1_awready = awready_v[1];
    assign m0_wready  = wready_v[0];
    assign m1_wready  = wready_v[1];
    assign m0_arready = arready_v[0];
    assign m1_arready = arready_v[1];
    assign m0_bvalid  = bvalid_v[0];
    assign m1_bvalid  = bvalid_v[1];
    assign m0_rvalid  = rvalid_v[0];
    assign m1_rvalid  = rvalid_v[1];

    assign m0_bresp = s_bresp;
    assign m1_bresp = s_bresp;
    assign m0_bid   = s_bid[IDW-1:0];
    assign m1_bid   = s_bid[IDW-1:0];
    assign m0_rdata = s_rdata;
    assign m1_rdata = s_rdata;
    assign m0_rresp = s_rresp;
    assign m1_rresp = s_rresp;
    assign m0_rid   = s_rid[IDW-1:0];
    assign m1_rid   = s_rid[IDW-1:0];
    assign m0_rlast = s_rlast;
    assign m1_rlast = s_rlast;

    // last_grant resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_reg      <= IDLE;
            grant_reg      <= 1'b0;
            last_grant_reg <= 1'b1;
            aw_done_reg    <= 1'b0;
            w_done_reg     <= 1'b0;
        end else begin
            state_reg      <= state_next;
            grant_reg      <= grant_next;
            last_grant_reg <= last_grant_next;
            aw_done_reg    <= aw_done_next;
            w_done_reg     <= w_done_next;
        end
    end

    assign busy_o  = (state_reg != IDLE);
    assign grant_o = grant_reg;

endmodule

// File: tb/tb_axi_port_arbiter.sv
// Randomized bench for axi_port_arbiter: bench-owned masters and slave, checked against a
// transaction-level round-robin model, plus directed reset scenarios.
module tb_axi_port_arbiter;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int IDW = 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic            m_awvalid [2], m_awready [2], m_wvalid [2], m_wready [2];
    logic            m_bvalid [2], m_bready [2], m_arvalid [2], m_arready [2];
    logic            m_rvalid [2], m_rready [2], m_rlast [2];
    logic [AW-1:0]   m_awaddr [2], m_araddr [2];
    logic [IDW-1:0]  m_awid [2], m_arid [2], m_bid [2], m_rid [2];
    logic [DW-1:0]   m_wdata [2], m_rdata [2];
    logic [DW/8-1:0] m_wstrb [2];
    logic [1:0]      m_bresp [2], m_rresp [2];

    logic            s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
    logic            s_arvalid, s_arready, s_rvalid, s_rready, s_rlast;
    logic [AW-1:0]   s_awaddr, s_araddr;
    logic [IDW:0]    s_awid, s_arid, s_bid, s_rid;
    logic [DW-1:0]   s_wdata, s_rdata;
    logic [DW/8-1:0] s_wstrb;
    logic [1:0]      s_bresp, s_rresp;
    logic            busy_o, grant_o;

    axi_port_arbiter #(.AW(AW), .DW(DW), .IDW(IDW)) dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n),
        .m0_awvalid(m_awvalid[0]), .m0_awready(m_awready[0]), .m0_awaddr(m_awaddr[0]), .m0_awid(m_awid[0]),
        .m0_wvalid(m_wvalid[0]), .m0_wready(m_wready[0]), .m0_wdata(m_wdata[0]), .m0_wstrb(m_wstrb[0]),
        .m0_bvalid(m_bvalid[0]), .m0_bready(m_bready[0]), .m0_bresp(m_bresp[0]), .m0_bid(m_bid[0]),
        .m0_arvalid(m_arvalid[0]), .m0_arready(m_arready[0]), .m0_araddr(m_araddr[0]), .m0_arid(m_arid[0]),
        .m0_rvalid(m_rvalid[0]), .m0_rready(m_rready[0]), .m0_rdata(m_rdata[0]), .m0_rresp(m_rresp[0]),
        .m0_rid(m_rid[0]), .m0_rlast(m_rlast[0]),
        .m1_awvalid(m_awvalid[1]), .m1_awready(m_awready[1]), .m1_awaddr(m_awaddr[1]), .m1_awid(m_awid[1]),
        .m1_wvalid(m_wvalid[1]), .m1_wready(m_wready[1]), .m1_wdata(m_wdata[1]), .m1_wstrb(m_wstrb[1]),
        .m1_bvalid(m_bvalid[1]), .m1_bready(m_bready[1]), .m1_bresp(m_bresp[1]), .m1_bid(m_bid[1]),
        .m1_arvalid(m_arvalid[1]), .m1_arready(m_arready[1]), .m1_araddr(m_araddr[1]), .m1_arid(m_arid[1]),
        .m1_rvalid(m_rvalid[1]), .m1_rready(m_rready[1]), .m1_rdata(m_rdata[1]), .m1_rresp(m_rresp[1]),
        .m1_rid(m_rid[1]), .m1_rlast(m_rlast[1]),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awid(s_awid),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp), .s_bid(s_bid),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arid(s_arid),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
        .s_rid(s_rid), .s_rlast(s_rlast),
        .busy_o(busy_o), .grant_o(grant_o)
    );

    // master-side transaction slots
    bit              w_pend [2], w_aw_sent [2], w_w_sent [2], r_pend [2], r_ar_sent [2];
    logic [AW-1:0]   w_addr [2], r_addr [2];
    logic [DW-1:0]   w_data [2];
    logic [DW/8-1:0] w_strb [2];
    logic [IDW-1:0]  w_id [2], r_id [2];
    // slave responder
    bit              sl_aw_got, sl_w_got, sl_b_on, sl_ar_got, sl_r_on;
    int              sl_b_wait, sl_r_wait, sl_beats;
    logic [IDW:0]    sl_awid, sl_arid;
    logic [1:0]      sl_bresp, sl_rresp;
    logic [DW-1:0]   sl_rdata;
    // transaction-level arbitration model
    bit              mdl_busy, mdl_g, mdl_last, mdl_wr;
    bit              gen_en, rdy_all, hold_bready;
    int              checks, errors;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic new_write(input int i);
        w_pend[i] = 1; w_aw_sent[i] = 0; w_w_sent[i] = 0;
        w_addr[i] = AW'($urandom_range(0, 16'hFFFF));
        w_data[i] = $urandom;
        w_strb[i] = 4'($urandom_range(0, 15));
        w_id[i]   = 1'($urandom_range(0, 1));
    endtask

    task automatic new_read(input int i);
        r_pend[i] = 1; r_ar_sent[i] = 0;
        r_addr[i] = AW'($urandom_range(0, 16'hFFFF));
        r_id[i]   = 1'($urandom_range(0, 1));
    endtask

    task automatic step();
        int  g, o;
        bit  ended, req0, req1, pick;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            if (gen_en && !w_pend[i] && $urandom_range(0, 3) == 0) new_write(i);
            if (gen_en && !r_pend[i] && $urandom_range(0, 3) == 0) new_read(i);
            m_awvalid[i] = w_pend[i] && !w_aw_sent[i];
            m_wvalid[i]  = w_pend[i] && !w_w_sent[i];
            m_arvalid[i] = r_pend[i] && !r_ar_sent[i];
            m_awaddr[i] = w_addr[i]; m_awid[i] = w_id[i];
            m_wdata[i]  = w_data[i]; m_wstrb[i] = w_strb[i];
            m_araddr[i] = r_addr[i]; m_arid[i] = r_id[i];
            m_bready[i] = hold_bready ? 1'b0 : ($urandom_range(0, 3) != 0);
            m_rready[i] = $urandom_range(0, 3) != 0;
        end
        s_awready = rdy_all || ($urandom_range(0, 1) == 1);
        s_wready  = rdy_all || ($urandom_range(0, 1) == 1);
        s_arready = rdy_all || ($urandom_range(0, 1) == 1);
        s_bvalid = sl_b_on; s_bresp = sl_bresp; s_bid = sl_awid;
        s_rvalid = sl_r_on; s_rdata = sl_rdata; s_rresp = sl_rresp; s_rid = sl_arid;
        s_rlast  = (sl_beats == 1);
        #1;
        g = int'(mdl_g); o = 1 - g;
        check_eq("busy", busy_o, mdl_busy);
        check_eq("grant", grant_o, mdl_g);
        if (!mdl_busy)
            check_eq("idle_quiet", {s_awvalid, s_wvalid, s_arvalid, s_bready, s_rready,
                     m_awready[0], m_wready[0], m_arready[0], m_bvalid[0], m_rvalid[0],
                     m_awready[1], m_wready[1], m_arready[1], m_bvalid[1], m_rvalid[1]}, 0);
        else
            check_eq("other_quiet", {m_awready[o], m_wready[o], m_arready[o], m_bvalid[o], m_rvalid[o]}, 0);
        ended = 0;
        if (s_awvalid && s_awready) begin
            check_eq("aw_lane", {mdl_busy, mdl_wr, m_awvalid[g], m_awready[g]}, 4'hF);
            check_eq("awaddr", s_awaddr, w_addr[g]);
            check_eq("awid", s_awid, {mdl_g, w_id[g]});
            sl_aw_got = 1; sl_awid = s_awid; sl_b_wait = $urandom_range(0, 3);
        end
        if (s_wvalid && s_wready) begin
            check_eq("w_lane", {mdl_busy, mdl_wr, m_wvalid[g], m_wready[g]}, 4'hF);
            check_eq("wdata", s_wdata, w_data[g]);
            check_eq("wstrb", s_wstrb, w_strb[g]);
            sl_w_got = 1;
        end
        if (s_arvalid && s_arready) begin
            check_eq("ar_lane", {mdl_busy, !mdl_wr, m_arvalid[g], m_arready[g]}, 4'hF);
            check_eq("araddr", s_araddr, r_addr[g]);
            check_eq("arid", s_arid, {mdl_g, r_id[g]});
            sl_ar_got = 1; sl_arid = s_arid;
            sl_r_wait = $urandom_range(0, 5); sl_beats = $urandom_range(1, 2);
        end
        if (s_bvalid && s_bready) begin
            check_eq("b_lane", {mdl_busy, mdl_wr, m_bvalid[g], m_bready[g]}, 4'hF);
            check_eq("bresp", m_bresp[g], sl_bresp);
            check_eq("bid", m_bid[g], w_id[g]);
            $display("txn m%0d wr addr=%0h data=%0h bresp=%0d", g, w_addr[g], w_data[g], sl_bresp);
            w_pend[g] = 0; sl_b_on = 0; sl_aw_got = 0; sl_w_got = 0; ended = 1;
        end
        if (s_rvalid && s_rready) begin
            check_eq("r_lane", {mdl_busy, !mdl_wr, m_rvalid[g], m_rready[g]}, 4'hF);
            check_eq("rdata", m_rdata[g], sl_rdata);
            check_eq("rresp", m_rresp[g], sl_rresp);
            check_eq("rid", m_rid[g], r_id[g]);
            check_eq("rlast", m_rlast[g], sl_beats == 1);
            if (sl_beats == 1) begin
                $display("txn m%0d rd addr=%0h data=%0h rresp=%0d", g, r_addr[g], sl_rdata, sl_rresp);
                r_pend[g] = 0; sl_r_on = 0; sl_ar_got = 0; ended = 1;
            end else begin
                sl_beats--; sl_rdata = $urandom; sl_rresp = 2'($urandom_range(0, 3));
            end
        end
        for (int i = 0; i < 2; i++) begin
            if (m_awvalid[i] && m_awready[i]) w_aw_sent[i] = 1;
            if (m_wvalid[i] && m_wready[i])   w_w_sent[i] = 1;
            if (m_arvalid[i] && m_arready[i]) r_ar_sent[i] = 1;
        end
        // Round robin over whole transactions; a request seen in the ending cycle waits one cycle.
        if (ended) begin
            mdl_busy = 0; mdl_last = mdl_g;
        end else if (!mdl_busy) begin
            req0 = (m_awvalid[0] && m_wvalid[0]) || m_arvalid[0];
            req1 = (m_awvalid[1] && m_wvalid[1]) || m_arvalid[1];
            if (req0 || req1) begin
                pick = (req0 && req1) ? !mdl_last : req1;
                mdl_g = pick; mdl_busy = 1;
                mdl_wr = m_awvalid[int'(pick)] && m_wvalid[int'(pick)];
            end
        end
        if (sl_aw_got && sl_w_got && !sl_b_on) begin
            if (sl_b_wait > 0) sl_b_wait--;
            else begin sl_b_on = 1; sl_bresp = 2'($urandom_range(0, 3)); end
        end
        if (sl_ar_got && !sl_r_on) begin
            if (sl_r_wait > 0) sl_r_wait--;
            else begin sl_r_on = 1; sl_rdata = $urandom; sl_rresp = 2'($urandom_range(0, 3)); end
        end
    endtask

    task automatic clear_inputs();
        for (int i = 0; i < 2; i++) begin
            m_awvalid[i] = 0; m_wvalid[i] = 0; m_arvalid[i] = 0; m_bready[i] = 0; m_rready[i] = 0;
            w_pend[i] = 0; r_pend[i] = 0;
        end
        s_awready = 0; s_wready = 0; s_arready = 0; s_bvalid = 0; s_rvalid = 0; s_rlast = 0;
        sl_aw_got = 0; sl_w_got = 0; sl_b_on = 0; sl_ar_got = 0; sl_r_on = 0; sl_beats = 0;
        mdl_busy = 0; mdl_g = 0; mdl_last = 1; mdl_wr = 0;
    endtask

    initial begin
        checks = 0; errors = 0;
        gen_en = 0; rdy_all = 0; hold_bready = 0;
        rst_n = 0;
        // Reset holds everything quiet even with every valid asserted.
        for (int i = 0; i < 2; i++) begin
            m_awvalid[i] = 1; m_wvalid[i] = 1; m_arvalid[i] = 1; m_bready[i] = 1; m_rready[i] = 1;
            m_awaddr[i] = '0; m_araddr[i] = '0; m_awid[i] = '0; m_arid[i] = '0;
            m_wdata[i] = '0; m_wstrb[i] = '0;
        end
        s_awready = 1; s_wready = 1; s_arready = 1; s_bvalid = 1; s_rvalid = 1; s_rlast = 1;
        s_bresp = 0; s_bid = 0; s_rdata = 0; s_rresp = 0; s_rid = 0;
        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_s_side", {s_awvalid, s_wvalid, s_arvalid, s_bready, s_rready}, 0);
        check_eq("rst_m_side", {m_awready[0], m_wready[0], m_arready[0], m_bvalid[0], m_rvalid[0],
                 m_awready[1], m_wready[1], m_arready[1], m_bvalid[1], m_rvalid[1]}, 0);
        check_eq("rst_busy", busy_o, 0);
        check_eq("rst_grant", grant_o, 0);
        clear_inputs();
        new_write(0);
        new_read(1);
        rst_n = 1;

        gen_en = 1;
        repeat (3000) step();

        gen_en = 0;
        for (int k = 0; k < 2000 && (w_pend[0] || w_pend[1] || r_pend[0] || r_pend[1] || mdl_busy); k++) step();
        check_eq("drain_done", {w_pend[0], w_pend[1], r_pend[0], r_pend[1], mdl_busy}, 0);

        // Reset while the slave holds B valid: response must vanish at once.
        rdy_all = 1; hold_bready = 1;
        new_write(0);
        for (int k = 0; k < 50 && !sl_b_on; k++) step();
        check_eq("b_reached", sl_b_on, 1);
        step();
        check_eq("pre_rst_bvalid", m_bvalid[0], 1);
        rst_n = 0;
        #1;
        check_eq("rst_mid_bvalid", m_bvalid[0], 0);
        check_eq("rst_mid_busy", busy_o, 0);
        check_eq("rst_mid_sbready", s_bready, 0);
        rdy_all = 0; hold_bready = 0;
        clear_inputs();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        new_read(1);
        for (int k = 0; k < 100 && r_pend[1]; k++) step();
        check_eq("m1_read_done", r_pend[1], 0);
        check_eq("m1_grant_after_rst", grant_o, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
